// File: rtl/usb_fifo_port_arbiter.sv
// Arbitrates the USB data-FIFO SRAM between the OTG core (absolute priority, zero latency)
// and a debug access port that slips its single op into a core-idle cycle or times out.
module usb_fifo_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 35,
    parameter int TIMEOUT = 255
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              ctrl_ce_n,
    input  logic              ctrl_we_n,
    input  logic [ADDR_W-1:0] ctrl_addr,
    input  logic [DATA_W-1:0] ctrl_wdata,
    output logic [DATA_W-1:0] ctrl_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_busy,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_latch;
    logic               w_dbg_issue;
    logic               r_op_we;
    logic [ADDR_W-1:0]  r_op_addr;
    logic [DATA_W-1:0]  r_op_wdata;
    logic               r_rd_d;
    logic [DATA_W-1:0]  r_hold;
    logic [DATA_W-1:0]  r_dbg_rdata;
    logic               w_resp;
    logic               w_resp_rd;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        w_dbg_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dbg_req) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ctrl_ce_n) begin
                    w_dbg_issue = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_RESP;
                end else begin
                    // Blocked by the core; the count saturates instead of wrapping.
                    if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
                    if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_op_we     <= 1'b0;
            r_op_addr   <= '0;
            r_op_wdata  <= '0;
            r_rd_d      <= 1'b0;
            r_hold      <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            if (w_latch) begin
                r_op_we    <= dbg_we;
                r_op_addr  <= dbg_addr;
                r_op_wdata <= dbg_wdata;
            end
            r_rd_d <= ~ctrl_ce_n & ctrl_we_n;
            if (r_rd_d) r_hold <= sram_dout;
            if (w_resp_rd) r_dbg_rdata <= sram_dout;
        end
    end

    // Gate with reset so a pending op never produces a stray ack or busy while in reset.
    assign w_resp     = (r_state == ST_RESP) && !areset;
    assign w_resp_rd  = w_resp & ~r_err & ~r_op_we;
    assign dbg_ack    = w_resp;
    assign dbg_err    = w_resp & r_err;
    assign dbg_busy   = (r_state != ST_IDLE) && !areset;
    assign dbg_rdata  = w_resp_rd ? sram_dout : r_dbg_rdata;
    assign ctrl_rdata = r_rd_d ? sram_dout : r_hold;

    always_comb begin
        sram_ce_n = 1'b1;
        sram_we_n = 1'b1;
        sram_addr = ctrl_addr;
        sram_din  = ctrl_wdata;
        if (!areset) begin
            if (!ctrl_ce_n) begin
                sram_ce_n = 1'b0;
                sram_we_n = ctrl_we_n;
            end else if (w_dbg_issue) begin
                sram_ce_n = 1'b0;
                sram_we_n = ~r_op_we;
                sram_addr = r_op_addr;
                sram_din  = r_op_wdata;
            end
        end
    end

endmodule

// File: tb/tb_usb_fifo_port_arbiter.sv
// Bench for usb_fifo_port_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_usb_fifo_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 35;
    localparam int TO = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ctrl_ce_n, ctrl_we_n;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_wdata, ctrl_rdata;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          dbg_ack, dbg_err, dbg_busy;
    logic          sram_ce_n, sram_we_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;

    logic [DW-1:0] sram_mem [4096];
    logic [DW-1:0] mem_ref  [4096];

    usb_fifo_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .aclk(aclk), .areset(areset),
        .ctrl_ce_n(ctrl_ce_n), .ctrl_we_n(ctrl_we_n), .ctrl_addr(ctrl_addr),
        .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata), .dbg_busy(dbg_busy),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 aclk = ~aclk;

    // Single-port synchronous SRAM macro.
    always @(posedge aclk) begin
        if (!sram_ce_n) begin
            if (!sram_we_n) sram_mem[sram_addr] <= sram_din;
            else            sram_dout <= sram_mem[sram_addr];
        end
    end

    // Transaction-level model state.
    bit            m_pend, m_resp, m_err, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ctrl_rdata, m_dbg_rdata;
    int            m_wait;

    int            n_checks = 0;
    int            n_errs   = 0;
    logic          last_ack, last_err, last_busy, last_ce_n;
    logic [DW-1:0] last_dbg_rdata, last_ctrl_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (areset) begin
            m_pend = 0; m_resp = 0; m_err = 0;
            m_ctrl_rdata = '0; m_dbg_rdata = '0;
            return;
        end
        if (!ctrl_ce_n) begin
            if (!ctrl_we_n) mem_ref[ctrl_addr] = ctrl_wdata;
            else            m_ctrl_rdata = mem_ref[ctrl_addr];
        end
        if (m_resp) begin
            m_resp = 0;
        end else if (m_pend) begin
            if (ctrl_ce_n) begin
                if (m_we) mem_ref[m_addr] = m_wdata;
                else      m_dbg_rdata = mem_ref[m_addr];
                m_pend = 0; m_resp = 1; m_err = 0;
            end else begin
                m_wait++;
                if (TO != 0 && m_wait == TO) begin
                    m_pend = 0; m_resp = 1; m_err = 1;
                end
            end
        end else if (dbg_req) begin
            m_pend = 1; m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; m_wait = 0;
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then step past the edge.
    task automatic cyc();
        logic          e_ce_n, e_we_n;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        @(negedge aclk);
        if (areset) begin
            check("rst_sram_ce_n", sram_ce_n, 1'b1);
            check("rst_sram_we_n", sram_we_n, 1'b1);
            check("rst_ack", dbg_ack, 1'b0);
            check("rst_busy", dbg_busy, 1'b0);
        end else begin
            e_ce_n = 1'b1; e_we_n = 1'b1; e_addr = ctrl_addr; e_din = ctrl_wdata;
            if (!ctrl_ce_n) begin
                e_ce_n = 1'b0; e_we_n = ctrl_we_n;
            end else if (m_pend) begin
                e_ce_n = 1'b0; e_we_n = ~m_we; e_addr = m_addr; e_din = m_wdata;
            end
            check("sram_ce_n", sram_ce_n, e_ce_n);
            check("sram_we_n", sram_we_n, e_we_n);
            if (!e_ce_n) check("sram_addr", sram_addr, e_addr);
            if (!e_ce_n && !e_we_n) check("sram_din", sram_din, e_din);
            check("dbg_ack", dbg_ack, m_resp);
            if (m_resp) check("dbg_err", dbg_err, m_err);
            check("dbg_busy", dbg_busy, m_pend || m_resp);
            check("dbg_rdata", dbg_rdata, m_dbg_rdata);
            check("ctrl_rdata", ctrl_rdata, m_ctrl_rdata);
        end
        last_ack = dbg_ack; last_err = dbg_err; last_busy = dbg_busy; last_ce_n = sram_ce_n;
        last_dbg_rdata = dbg_rdata; last_ctrl_rdata = ctrl_rdata;
        model_step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        last_ack = 1'b0;
        while (!last_ack && n < 50) begin
            cyc();
            n++;
        end
        check("ack_seen", last_ack, 1'b1);
    endtask

    task automatic core_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ctrl_ce_n = 1'b0; ctrl_we_n = 1'b0; ctrl_addr = a; ctrl_wdata = d;
        cyc();
        ctrl_ce_n = 1'b1; ctrl_we_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [8:0] ack_mask;

        areset = 1'b1;
        ctrl_ce_n = 1'b1; ctrl_we_n = 1'b1; ctrl_addr = '0; ctrl_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) cyc();
        areset = 1'b0;
        cyc();
        check("rst_ctrl_rdata", last_ctrl_rdata, '0);
        check("rst_dbg_rdata", last_dbg_rdata, '0);

        // Preload the low 64 words through the core port.
        for (int a = 0; a < 64; a++) core_wr(AW'(a), DW'({$urandom(), $urandom()}));
        core_wr(12'h020, 35'h123);
        core_wr(12'h030, 35'h7);
        core_wr(12'h031, 35'h9);
        core_wr(12'h03A, 35'hAA);
        cyc();

        // Debug write then read with the core idle: ack two cycles after the request.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h010; dbg_wdata = 35'h5_A5A5_A5A5;
        cyc();
        dbg_req = 1'b0;
        wait_ack(n);
        check("dw_latency", n, 2);
        check("dw_err", last_err, 1'b0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h010;
        cyc();
        dbg_req = 1'b0;
        wait_ack(n);
        check("dr_latency", n, 2);
        check("dr_err", last_err, 1'b0);
        check("dr_data", last_dbg_rdata, 35'h5_A5A5_A5A5);
        cyc();

        // Core streams reads of 0x020; debug op waits for the first idle core cycle.
        ctrl_ce_n = 1'b0; ctrl_we_n = 1'b1; ctrl_addr = 12'h020;
        cyc(); cyc();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h02F;
        cyc();
        check("t2_ctrl_rd0", last_ctrl_rdata, 35'h123);
        dbg_req = 1'b0;
        cyc();
        check("t2_ctrl_rd1", last_ctrl_rdata, 35'h123);
        check("t2_busy", last_busy, 1'b1);
        cyc();
        check("t2_ctrl_rd2", last_ctrl_rdata, 35'h123);
        ctrl_ce_n = 1'b1;
        wait_ack(n);
        check("t2_latency", n, 2);
        check("t2_ctrl_hold", last_ctrl_rdata, 35'h123);
        check("t2_dbg_rdata", last_dbg_rdata, mem_ref[12'h02F]);
        cyc();

        // Core read of 0x030 must stay on ctrl_rdata across a debug read of 0x031.
        ctrl_ce_n = 1'b0; ctrl_we_n = 1'b1; ctrl_addr = 12'h030;
        cyc();
        ctrl_ce_n = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h031;
        cyc();
        check("t3_ctrl_rd", last_ctrl_rdata, 35'h7);
        dbg_req = 1'b0;
        wait_ack(n);
        check("t3_latency", n, 2);
        check("t3_ctrl_hold", last_ctrl_rdata, 35'h7);
        check("t3_dbg_rdata", last_dbg_rdata, 35'h9);
        cyc();

        // Core never idle: debug write times out five cycles after the request.
        ctrl_ce_n = 1'b0; ctrl_we_n = 1'b1; ctrl_addr = 12'h020;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h03A; dbg_wdata = 35'h7_FFFF_0000;
        cyc();
        dbg_req = 1'b0;
        wait_ack(n);
        check("t4_latency", n, TO + 1);
        check("t4_err", last_err, 1'b1);
        ctrl_ce_n = 1'b1;
        cyc();
        check("t4_mem", sram_mem[12'h03A], 35'hAA);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h03A;
        cyc();
        dbg_req = 1'b0;
        wait_ack(n);
        check("t4_readback", last_dbg_rdata, 35'hAA);
        cyc();

        // Reset while waiting: op dropped silently, then a fresh op completes.
        ctrl_ce_n = 1'b0; ctrl_we_n = 1'b1; ctrl_addr = 12'h020;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h03B; dbg_wdata = 35'h1_2345_6789;
        cyc();
        dbg_req = 1'b0;
        cyc();
        check("t5_busy_wait", last_busy, 1'b1);
        areset = 1'b1;
        cyc();
        check("t5_rst_busy", last_busy, 1'b0);
        check("t5_rst_ce_n", last_ce_n, 1'b1);
        cyc();
        areset = 1'b0; ctrl_ce_n = 1'b1;
        cyc();
        check("t5_no_ack", last_ack, 1'b0);
        check("t5_idle", last_busy, 1'b0);
        dbg_req = 1'b1;
        cyc();
        dbg_req = 1'b0;
        wait_ack(n);
        check("t5_latency", n, 2);
        check("t5_err", last_err, 1'b0);
        cyc();

        // Request held high: back-to-back ops acked every third cycle.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h010;
        ack_mask = '0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            ack_mask[i] = last_ack;
        end
        dbg_req = 1'b0;
        check("t6_ack_pattern", ack_mask, 9'b100_100_100);
        repeat (3) cyc();

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            areset     = ($urandom_range(0, 199) == 0);
            ctrl_ce_n  = ($urandom_range(0, 9) < 4);
            ctrl_we_n  = ($urandom_range(0, 2) != 0);
            ctrl_addr  = AW'($urandom_range(0, 63));
            ctrl_wdata = DW'({$urandom(), $urandom()});
            dbg_req    = ($urandom_range(0, 2) == 0);
            dbg_we     = $urandom_range(0, 1) != 0;
            dbg_addr   = AW'($urandom_range(0, 63));
            dbg_wdata  = DW'({$urandom(), $urandom()});
            cyc();
        end
        areset = 1'b0; ctrl_ce_n = 1'b1; ctrl_we_n = 1'b1; dbg_req = 1'b0;
        repeat (8) cyc();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_fifo_port_arbiter.md
Name: usb_fifo_port_arbiter

Overview:
Shares the USB controller's single-port 4096x35 data-FIFO SRAM between two users: the OTG core, which has absolute priority and is never stalled, and a debug/diagnostic access port with a request/ack handshake. Debug accesses are inserted only in cycles where the core leaves the SRAM idle, and abort with an error after a bounded wait. Sits between the core's dfifo_h_* pins and the SRAM macro (ASIC or FPGA variant) inside the USB wrapper.

Parameters:
ADDR_W, 12, SRAM address width
DATA_W, 35, SRAM data width
TIMEOUT, 255, consecutive blocked cycles before a pending debug op aborts; 0 = never abort

Ports:
aclk  in  1  single clock for all logic
areset  in  1  synchronous, active-high reset
ctrl_ce_n  in  1  core chip enable, active low
ctrl_we_n  in  1  core write enable, active low
ctrl_addr  in  ADDR_W  core address
ctrl_wdata  in  DATA_W  core write data
ctrl_rdata  out  DATA_W  core read data, SRAM-equivalent semantics
dbg_req  in  1  debug request
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_err  out  1  valid with dbg_ack; 1 = timed out, op not performed
dbg_rdata  out  DATA_W  read data, valid with dbg_ack (read, no error), held until next ack
dbg_busy  out  1  debug op accepted and not yet acked
sram_ce_n  out  1  to SRAM, active low
sram_we_n  out  1  to SRAM, active low
sram_addr  out  ADDR_W  to SRAM
sram_din  out  DATA_W  to SRAM
sram_dout  in  DATA_W  from SRAM, valid 1 cycle after a read enable

Behaviour:
- Reset values: dbg_ack=0, dbg_err=0, dbg_rdata=0, dbg_busy=0, ctrl_rdata=0, FSM=IDLE, timeout count=0. While areset=1, sram_ce_n=sram_we_n=1 (forced).
- Core path is combinational, zero added latency: when ctrl_ce_n=0, the sram_* outputs equal the ctrl_* inputs in the same cycle, regardless of debug state.
- ctrl_rdata hold: rd_d is a register = (ctrl_ce_n=0 and ctrl_we_n=1) from the previous cycle. ctrl_rdata = rd_d ? sram_dout : hold_q. hold_q <= sram_dout when rd_d. Debug reads must never change ctrl_rdata.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: dbg_req=1 latches dbg_we/addr/wdata into an op register and moves to WAIT with count cleared. dbg_req is sampled only in IDLE.
  - WAIT, ctrl_ce_n=1: drive sram_* from the op register (ce_n=0, we_n=~op_we) and go to RESP with err=0.
  - WAIT, ctrl_ce_n=0 (blocked): count++. If TIMEOUT!=0 and count==TIMEOUT-1, go to RESP with err=1 and issue no SRAM op.
  - RESP: dbg_ack=1 for exactly one cycle and dbg_err=err. On a successful read, dbg_rdata <= sram_dout. Next state is IDLE.
- Minimum latency: request in IDLE at cycle T, SRAM op at T+1, dbg_ack at T+2. The requester deasserts dbg_req by the ack cycle. A req still high in the cycle after ack starts a new op.
- dbg_busy = (state != IDLE).
- When no one is accessing, sram_ce_n=1 and sram_we_n=1. The other sram_* outputs are don't-care, but driven from the ctrl inputs.
- Timeout count width is clog2(TIMEOUT+1). It saturates and never wraps.
- Reset mid-op discards the pending op with no ack.
- Core and debug accessing the same address: the core always wins. A debug read issued after a core write returns the written data.

Test Plan:
- Debug write 0x5_A5A5_A5A5 to addr 0x010 while the core is idle, then a debug read of 0x010 -> ack 2 cycles after each req, err=0, dbg_rdata=0x5_A5A5_A5A5.
- Core reads addr 0x020 (preloaded 0x123) continuously. A debug req arrives -> the op issues only in the first ctrl_ce_n=1 cycle. Every core read returns 0x123 on the next cycle. No glitch in ctrl_rdata.
- Core reads 0x030 (value 0x7), then goes idle; debug reads 0x031 (value 0x9) -> ctrl_rdata holds 0x7 across the debug read, and dbg_rdata=0x9.
- TIMEOUT=4, ctrl_ce_n held 0, debug write req -> ack with err=1 exactly 5 cycles after the req cycle, and the SRAM content at the target addr is unchanged.
- areset asserted during WAIT -> no ack, busy=0, sram_ce_n=1 during reset. After reset release, a new req completes normally.
- dbg_req held high across ack -> back-to-back ops, ack every 3 cycles with the core idle.
